// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key codes are {row_idx, col_idx} on a standard hex keypad layout.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

    localparam logic [3:0] COLS_RESET = 4'b1110;

    localparam logic [3:0] KEY_1    = 4'b0000;
    localparam logic [3:0] KEY_2    = 4'b0001;
    localparam logic [3:0] KEY_3    = 4'b0010;
    localparam logic [3:0] KEY_A    = 4'b0011;
    localparam logic [3:0] KEY_4    = 4'b0100;
    localparam logic [3:0] KEY_5    = 4'b0101;
    localparam logic [3:0] KEY_6    = 4'b0110;
    localparam logic [3:0] KEY_B    = 4'b0111;
    localparam logic [3:0] KEY_7    = 4'b1000;
    localparam logic [3:0] KEY_8    = 4'b1001;
    localparam logic [3:0] KEY_9    = 4'b1010;
    localparam logic [3:0] KEY_C    = 4'b1011;
    localparam logic [3:0] KEY_STAR = 4'b1100;
    localparam logic [3:0] KEY_0    = 4'b1101;
    localparam logic [3:0] KEY_HASH = 4'b1110;
    localparam logic [3:0] KEY_D    = 4'b1111;

    // True when exactly one row line is pulled low (a single, unambiguous key).
    function automatic logic single_low(input logic [3:0] r);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++)
            if (!r[i]) n++;
        return (n == 1);
    endfunction

    function automatic logic [1:0] low_idx(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!r[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix lines plus decoded key outputs.
// master = keypad/consumer side, slave = scanner side.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (output rows, input cols, key_code, key_valid, key_held);
    modport slave  (input rows, output cols, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner_scan_tick.sv
// Free-running divider: one-clk tick every SCAN_DIV clocks.
module scan_tick #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)              cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row sync, debounce, single-key decode.
// Define KEYPAD_REPEAT_EN to get auto-repeat key_valid pulses while held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.slave  kp
);
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

    generate
        if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
            $error("keypad_scanner: parameter out of range");
        end
    endgenerate

    logic       tick;
    logic [3:0] r_meta, rs;
    state_t     state;
    logic [3:0] cols_q, row_pat, code_q;
    logic [1:0] col_idx, row_idx;
    logic [DW-1:0] deb_cnt, rel_cnt;
    logic       valid_q, held_q;

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    logic [RW-1:0] rep_cnt;
    logic          rep_first;
`endif

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    // rows are asynchronous to clk; every decision below uses rs only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 4'b1111;
            rs     <= 4'b1111;
        end else begin
            r_meta <= kp.rows;
            rs     <= r_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCAN;
            cols_q  <= COLS_RESET;
            col_idx <= 2'd0;
            row_idx <= 2'd0;
            row_pat <= 4'b1111;
            deb_cnt <= '0;
            rel_cnt <= '0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            valid_q <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (single_low(rs)) begin
                            row_idx <= low_idx(rs);
                            row_pat <= rs;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            cols_q  <= {cols_q[2:0], cols_q[3]};
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    DEBOUNCE: begin
                        // A mismatch retries the same column rather than moving on.
                        if (rs != row_pat) begin
                            state <= SCAN;
                        end else if (deb_cnt == DEB_LAST) begin
                            code_q  <= {row_idx, col_idx};
                            valid_q <= 1'b1;
                            held_q  <= 1'b1;
                            rel_cnt <= '0;
                            state   <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt   <= '0;
                            rep_first <= 1'b1;
`endif
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (rs == 4'b1111) begin
                            if (rel_cnt == DEB_LAST) begin
                                held_q  <= 1'b0;
                                cols_q  <= {cols_q[2:0], cols_q[3]};
                                col_idx <= col_idx + 2'd1;
                                state   <= SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + 1'b1;
                            end
                        end else begin
                            rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            // Repeats stop as soon as a release tick has been seen.
                            if (rel_cnt == '0) begin
                                if (rep_cnt == (rep_first ? RW'(REPEAT_DELAY - 1)
                                                          : RW'(REPEAT_RATE - 1))) begin
                                    valid_q   <= 1'b1;
                                    rep_cnt   <= '0;
                                    rep_first <= 1'b0;
                                end else begin
                                    rep_cnt <= rep_cnt + 1'b1;
                                end
                            end
`endif
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign kp.cols      = cols_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3.
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (.clk(clk), .rst(rst), .kp(kif));

    // Up to two pressed keys; a key pulls its row low only while its column is driven.
    logic       ka_en = 1'b0, kb_en = 1'b0;
    logic [1:0] ka_r = 2'd0, ka_c = 2'd0, kb_r = 2'd0, kb_c = 2'd0;
    always_comb begin
        kif.rows = 4'b1111;
        if (ka_en && !kif.cols[ka_c]) kif.rows[ka_r] = 1'b0;
        if (kb_en && !kif.cols[kb_c]) kif.rows[kb_r] = 1'b0;
    end

    int n_tests = 0, n_fail = 0;
    int vcnt = 0, dbl = 0;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            vcnt++;
            if (prev_v) dbl++;
        end
        prev_v = (kif.key_valid === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            cyc(1);
            if (kif.key_valid === 1'b1) break;
        end
        chk({tag, "_valid_seen"}, 32'(i < lim), 32'd1);
    endtask

    task automatic wait_release(input string tag, input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            cyc(1);
            if (kif.key_held === 1'b0) break;
        end
        chk({tag, "_released"}, 32'(i < lim), 32'd1);
    endtask

    task automatic wait_cols(input int lim, output int n);
        logic [3:0] prev;
        prev = kif.cols;
        n = 0;
        while (n < lim) begin
            cyc(1);
            n++;
            if (kif.cols !== prev) break;
        end
    endtask

    initial begin
        int n, base;
        logic [3:0] rot [4];
        rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;

        // Reset with no key
        rst = 1'b1;
        cyc(3);
        chk("rst_cols",  32'(kif.cols),      32'h0000000e);
        chk("rst_valid", 32'(kif.key_valid), 32'd0);
        chk("rst_held",  32'(kif.key_held),  32'd0);
        chk("rst_code",  32'(kif.key_code),  32'd0);
        rst = 1'b0;

        // Idle column rotation, one step every 4 clk
        for (int k = 0; k < 4; k++) begin
            wait_cols(10, n);
            chk($sformatf("rot%0d_cols", k), 32'(kif.cols), 32'(rot[k]));
            chk($sformatf("rot%0d_gap", k),  32'(n),        32'd4);
        end

        // Clean press of (2,1)
        ka_r = 2'd2; ka_c = 2'd1; ka_en = 1'b1;
        wait_valid("p21", 200);
        chk("p21_code", 32'(kif.key_code), 32'h9);
        chk("p21_held", 32'(kif.key_held), 32'd1);
        base = vcnt;
        cyc(40);
`ifdef KEYPAD_REPEAT_EN
        chk("p21_repeats", 32'(vcnt - base), 32'd3);
`else
        chk("p21_single", 32'(vcnt - base), 32'd0);
`endif
        ka_en = 1'b0;
        wait_release("p21", 40);
        chk("p21_code_kept", 32'(kif.key_code), 32'h9);
        wait_cols(12, n);
        chk("p21_scan_resume", 32'(n < 12), 32'd1);

        // Bouncing (1,3): 5 clk on / 5 clk off, then steady
        ka_r = 2'd1; ka_c = 2'd3;
        base = vcnt;
        for (int k = 0; k < 8; k++) begin
            ka_en = ~ka_en;
            cyc(5);
        end
        chk("bounce_none", 32'(vcnt - base), 32'd0);
        ka_en = 1'b1;
        wait_valid("bounce", 100);
        chk("bounce_code", 32'(kif.key_code), 32'h7);
        ka_en = 1'b0;
        wait_release("bounce", 40);

        // Ghost: (0,2) and (3,2) together
        ka_r = 2'd0; ka_c = 2'd2; kb_r = 2'd3; kb_c = 2'd2;
        ka_en = 1'b1; kb_en = 1'b1;
        base = vcnt;
        cyc(80);
        chk("ghost_none", 32'(vcnt - base),   32'd0);
        chk("ghost_held", 32'(kif.key_held), 32'd0);
        wait_cols(8, n);
        chk("ghost_rotating", 32'(n < 8), 32'd1);
        ka_en = 1'b0; kb_en = 1'b0;
        cyc(4);

        // (1,1) held, then (3,0) added; only (1,1) until it is released
        ka_r = 2'd1; ka_c = 2'd1; ka_en = 1'b1;
        wait_valid("p11", 150);
        chk("p11_code", 32'(kif.key_code), 32'h5);
        kb_r = 2'd3; kb_c = 2'd0; kb_en = 1'b1;
        base = vcnt;
        cyc(60);
        chk("p11_code_kept", 32'(kif.key_code), 32'h5);
        chk("p11_held",      32'(kif.key_held), 32'd1);
`ifndef KEYPAD_REPEAT_EN
        chk("p11_second_ignored", 32'(vcnt - base), 32'd0);
`endif
        ka_en = 1'b0;
        cyc(4);
        wait_valid("p30", 150);
        chk("p30_code", 32'(kif.key_code), 32'hc);
        kb_en = 1'b0;
        wait_release("p30", 40);

        // Reset mid-debounce on (0,0)
        begin
            logic [3:0] prev;
            int i;
            for (i = 0; i < 20; i++) begin
                prev = kif.cols;
                cyc(1);
                if (kif.cols === 4'b1110 && prev !== 4'b1110) break;
            end
            chk("rstdb_col0_found", 32'(i < 20), 32'd1);
        end
        ka_r = 2'd0; ka_c = 2'd0; ka_en = 1'b1;
        cyc(6);
        base = vcnt;
        rst = 1'b1;
        cyc(2);
        chk("rstdb_cols",  32'(kif.cols),      32'h0000000e);
        chk("rstdb_valid", 32'(kif.key_valid), 32'd0);
        chk("rstdb_held",  32'(kif.key_held),  32'd0);
        chk("rstdb_code",  32'(kif.key_code),  32'd0);
        rst = 1'b0;
        ka_en = 1'b0;
        cyc(30);
        chk("rstdb_no_valid", 32'(vcnt - base), 32'd0);

        chk("valid_never_double", 32'(dbl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix 4x4 keypad reader; input-side counterpart of the counter/7-segment display path.
- Drives one keypad column low at a time and samples the four row lines.
- Debounces one key and reports it as a 4-bit code with a one-cycle valid pulse.
- Code feeds the control FSM in place of discrete push-buttons such as up.

Parameters:
- SCAN_DIV, 1000: clk cycles per scan tick; minimum 4.
- DEBOUNCE_TICKS, 4: consecutive stable ticks required to accept a press or a release; minimum 1.
- REPEAT_DELAY, 50: ticks from acceptance to first auto-repeat (KEYPAD_REPEAT_EN only).
- REPEAT_RATE, 10: ticks between subsequent repeats (KEYPAD_REPEAT_EN only).

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- rows  in  4  keypad rows, pulled up externally, active-low, asynchronous.
- cols  out  4  column drive, active-low, exactly one bit low at all times.
- key_code  out  4  last accepted key = {row_idx[1:0], col_idx[1:0]}.
- key_valid  out  1  one-clk pulse when key_code is (re)issued.
- key_held  out  1  high while the accepted key is considered pressed.

Behaviour:
- Reset values:
  - cols = 4'b1110; key_code = 0; key_valid = 0; key_held = 0.
  - State = SCAN; tick, debounce and repeat counters = 0; row synchronizer = 4'b1111.
- Input sync: rows pass through a 2-FF synchronizer. All decisions use the synced value rs.
- Tick: a free-running counter of 0..SCAN_DIV-1 pulses tick for one clk when it wraps. The tick counter is not reset by state changes.
- SCAN:
  - On tick, evaluate rs for the currently driven column.
  - rs has exactly one bit low: latch row_idx and col_idx, hold the column, zero the debounce counter, go to DEBOUNCE.
  - rs is all high, or two or more bits are low (ghosting/multi-press): advance the column 0→1→2→3→0 (cols 1110→1101→1011→0111→1110).
- DEBOUNCE (column frozen):
  - On each tick where rs equals the latched single-low pattern, increment the counter.
  - On any tick where rs differs, go to SCAN without advancing the column.
  - When the counter reaches DEBOUNCE_TICKS:
    - key_code <= {row_idx, col_idx}.
    - key_valid pulses on the next clk for exactly one cycle.
    - key_held <= 1.
    - Go to PRESSED.
- PRESSED (column frozen, key_held = 1):
  - On each tick where rs is all high, increment the release counter. Any tick with the row still low zeroes it.
  - Release counter reaching DEBOUNCE_TICKS: key_held <= 0, go to SCAN, advance the column.
  - A second key pressed while held is ignored.
- Latency: press to key_valid = (1 to SCAN_DIV) + DEBOUNCE_TICKS*SCAN_DIV + 2-3 clk.
- key_code keeps its value after release until the next acceptance.
- key_valid never asserts for two consecutive cycles.
- Reset asserted in any state returns all outputs and state to reset values on the next clk edge. No key_valid is emitted during or from reset.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter counts ticks.
  - After REPEAT_DELAY ticks, key_valid pulses again with the same key_code.
  - Afterwards, key_valid pulses every REPEAT_RATE ticks until release begins (release counter > 0).
  - The repeat counter clears on entering PRESSED.
- Undefined: exactly one key_valid per accepted press. REPEAT_* parameters are present but unused.

Decomposition:
- Package keypad_pkg contains:
  - The state enum (SCAN, DEBOUNCE, PRESSED).
  - Localparam COLS_RESET = 4'b1110.
  - Named key-code constants for the hex keypad layout, e.g. KEY_0, KEY_A.
- One sub-module, scan_tick: parameterised SCAN_DIV divider producing the one-clk tick.
- The synchronizer and FSM stay in keypad_scanner.

Test Plan:
Bench setting: SCAN_DIV=4, DEBOUNCE_TICKS=3. The keypad model pulls row r low only while cols[c]=0 for the pressed key (r,c).

- Reset: assert rst for 3 clk with no key → cols=1110, key_valid=0, key_held=0, key_code=0. Columns then rotate 1110→1101→1011→0111 every 4 clk.
- Clean press of (2,1) held 100 clk → exactly one key_valid pulse, key_code=4'b1001, key_held=1. Release → key_held=0 after 3 quiet ticks, then scanning resumes.
- Bounce: (1,3) toggles every 5 clk for 40 clk, then holds → no key_valid during the bounce; a single pulse with key_code=4'b0111 once stable for 3 ticks.
- Two keys (0,2) and (3,2) pressed simultaneously → two rows low, no acceptance, key_valid stays 0, columns keep rotating.
- Press (1,1), then press (3,0) while held → only code 4'b0101 is issued. (3,0) is accepted only after (1,1) is released while (3,0) is still held.
- rst pulsed mid-DEBOUNCE → outputs return to reset values and no key_valid appears. With KEYPAD_REPEAT_EN, REPEAT_DELAY=5, REPEAT_RATE=2, and a 60-clk hold → pulses at acceptance, +5 ticks, then every 2 ticks.
